din_stream_driver: RTL and testbench

- Synthesizable transmitter for the filter input interface (DIN/VIN).
- A loader pushes Nb-bit samples through a valid/ready port into an internal FIFO. A pacing FSM pops one sample per VIN pulse, with a programmable number of idle cycles between samples.
- After the last sample is sent, the block raises EOF.
- It sits between any sample source (host, ROM, file reader) and the IIR filter's DIN/VIN inputs, so the filter can be driven on-chip with controlled VIN gaps.

---
 rtl/din_stream_driver_pkg.sv | 15 +
 rtl/din_stream_driver_sample_fifo.sv | 45 ++++
 rtl/din_stream_driver.sv | 142 ++++++++++++++
 tb/tb_din_stream_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/din_stream_driver_pkg.sv
// Shared definitions for the DIN/VIN stream driver and the filter bench:
// pacing FSM encoding and default sample geometry.
package din_stream_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int NB_DEFAULT    = 10;
  localparam int DEPTH_DEFAULT = 8;

endpackage

// File: rtl/din_stream_driver_sample_fifo.sv
// Synchronous show-ahead FIFO holding samples between the loader and the
// pacing FSM; dout always presents the head word.
module sample_fifo
  import din_stream_driver_pkg::*;
#(
  parameter int W     = NB_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/din_stream_driver.sv
// Paces buffered samples onto the filter's DIN/VIN inputs with a programmable
// idle gap after each sample, and flags EOF once the final sample is sent.
module din_stream_driver
  import din_stream_driver_pkg::*;
#(
  parameter int Nb    = NB_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int GAP_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Nb-1:0]    LD_DATA,
  input  logic             LD_VALID,
  input  logic             LD_LAST,
  output logic             LD_READY,
  input  logic [GAP_W-1:0] GAP,
  input  logic             START,
  output logic [Nb-1:0]    DIN,
  output logic             VIN,
  output logic             EOF,
  output logic             BUSY,
  output logic [CNT_W-1:0] SENT_CNT,
  output state_t           STATE
);

  // Loader handshake: a word transfers on a rising edge where LD_VALID and
  // LD_READY are both high; LD_READY depends only on registered state, never
  // on LD_VALID, and stays low from the LD_LAST word until the next restart.

  state_t             state, state_n;
  logic [Nb-1:0]      din_q, din_n;
  logic               vin_q, vin_n;
  logic               eof_q, eof_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               last_seen;
  logic               clr_last;
  logic               fifo_pop;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [Nb-1:0]      fifo_head;

  assign LD_READY  = !fifo_full && !last_seen;
  assign fifo_push = LD_VALID && LD_READY;

  sample_fifo #(
    .W     (Nb),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (LD_DATA),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      din_q     <= '0;
      vin_q     <= 1'b0;
      eof_q     <= 1'b0;
      cnt_q     <= '0;
      gap_cnt   <= '0;
      last_seen <= 1'b0;
    end else begin
      state   <= state_n;
      din_q   <= din_n;
      vin_q   <= vin_n;
      eof_q   <= eof_n;
      cnt_q   <= cnt_n;
      gap_cnt <= gap_n;
      if (clr_last) begin
        last_seen <= 1'b0;
      end else if (fifo_push && LD_LAST) begin
        last_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    din_n    = din_q;
    vin_n    = 1'b0;
    eof_n    = eof_q;
    cnt_n    = cnt_q;
    gap_n    = gap_cnt;
    fifo_pop = 1'b0;
    clr_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          din_n    = fifo_head;
          vin_n    = 1'b1;
          cnt_n    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          gap_n    = GAP;
          if (GAP != '0) begin
            state_n = ST_GAP;
          end
        end else if (last_seen) begin
          state_n = ST_DONE;
          eof_n   = 1'b1;
        end
      end
      ST_GAP: begin
        // Entered with gap_cnt = GAP, leaving at 1 yields exactly GAP idle cycles.
        gap_n = gap_cnt - 1'b1;
        if (gap_cnt == GAP_W'(1)) begin
          state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        if (START) begin
          eof_n    = 1'b0;
          cnt_n    = '0;
          clr_last = 1'b1;
          state_n  = ST_RUN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign DIN      = din_q;
  assign VIN      = vin_q;
  assign EOF      = eof_q;
  assign SENT_CNT = cnt_q;
  assign BUSY     = (state == ST_RUN) || (state == ST_GAP);
  assign STATE    = state;

endmodule

// File: tb/tb_din_stream_driver.sv
// Directed bench for din_stream_driver: samples expected on DIN are queued when
// the loader hands them over and compared whenever VIN is seen high.
module tb_din_stream_driver;
  import din_stream_driver_pkg::*;

  localparam int NB    = 10;
  localparam int DEP   = 8;
  localparam int GAP_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NB-1:0]    ld_data;
  logic             ld_valid;
  logic             ld_last;
  logic             ld_ready;
  logic [GAP_W-1:0] gap;
  logic             start;
  logic [NB-1:0]    din;
  logic             vin;
  logic             eof;
  logic             busy;
  logic [CNT_W-1:0] sent_cnt;
  state_t           state;

  logic [NB-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  din_stream_driver #(
    .Nb    (NB),
    .DEPTH (DEP),
    .GAP_W (GAP_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .LD_DATA  (ld_data),
    .LD_VALID (ld_valid),
    .LD_LAST  (ld_last),
    .LD_READY (ld_ready),
    .GAP      (gap),
    .START    (start),
    .DIN      (din),
    .VIN      (vin),
    .EOF      (eof),
    .BUSY     (busy),
    .SENT_CNT (sent_cnt),
    .STATE    (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // inputs change 1 time unit after the edge; checks are made there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // present one word and hold it until the edge where LD_READY was high
  task automatic push_one(input logic [NB-1:0] d, input logic last);
    logic acc;
    int   n;
    ld_data  = d;
    ld_last  = last;
    ld_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      acc = ld_ready;
      step();
      n++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (acc) exp_q.push_back(d);
    else chk("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_eof(input int budget);
    int n;
    n = 0;
    while (!eof && n < budget) begin
      step();
      n++;
    end
    chk("eof_reached", 32'(eof), 32'd1);
  endtask

  // VIN captured over n cycles into bit i; DIN must hold while VIN is low
  task automatic capture(input int n, output logic [31:0] pat);
    logic [NB-1:0] prev;
    pat  = '0;
    prev = din;
    for (int i = 0; i < n; i++) begin
      step();
      pat[i] = vin;
      if (!vin) chk("din_hold", 32'(din), 32'(prev));
      prev = din;
    end
  endtask

  // scoreboard: every VIN pulse must match the next queued sample
  always @(negedge clk) begin
    if (!rst && vin) begin
      if (exp_q.size() == 0) chk("spurious_vin", 32'(vin), 32'd0);
      else chk("din_order", 32'(din), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [31:0] pat;
    int vcount;
    rst = 1'b1; ld_data = '0; ld_valid = 1'b0; ld_last = 1'b0; gap = '0; start = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_vin", 32'(vin), 32'd0);
    chk("rst_eof", 32'(eof), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(sent_cnt), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_state", 32'(state), 32'(ST_IDLE));

    // back-to-back with GAP=0 from a preloaded FIFO
    gap = 4'd0;
    push_one(10'h001, 1'b0);
    push_one(10'h1FF, 1'b0);
    push_one(10'h3FF, 1'b1);
    chk("last_blocks_ready", 32'(ld_ready), 32'd0);
    chk("idle_no_vin", 32'(vin), 32'd0);
    pulse_start();
    chk("first_vin_latency", 32'(vin), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
    capture(3, pat);
    chk("b2b_pattern", pat, 32'h7);
    step();
    chk("eof_after_last", 32'(eof), 32'd1);
    chk("eof_vin_low", 32'(vin), 32'd0);
    chk("cnt_3", 32'(sent_cnt), 32'd3);
    chk("busy_done", 32'(busy), 32'd0);

    // restart from DONE with START held through the first pulse
    start = 1'b1;
    step();
    chk("restart_eof_clr", 32'(eof), 32'd0);
    chk("restart_cnt_clr", 32'(sent_cnt), 32'd0);
    chk("restart_state", 32'(state), 32'(ST_RUN));
    push_one(10'h0AB, 1'b0);
    step();
    chk("start_ignored_cnt", 32'(sent_cnt), 32'd1);
    start = 1'b0;
    push_one(10'h154, 1'b1);
    wait_eof(20);
    chk("cnt_2", 32'(sent_cnt), 32'd2);

    // underflow: START on an empty FIFO, samples arrive later
    pulse_start();
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      vcount += int'(vin);
    end
    chk("underflow_no_vin", 32'(vcount), 32'd0);
    push_one(10'h155, 1'b0);
    chk("underflow_latency0", 32'(vin), 32'd0);
    step();
    chk("underflow_latency1", 32'(vin), 32'd1);
    chk("underflow_din", 32'(din), 32'h155);
    push_one(10'h2AA, 1'b1);
    wait_eof(20);

    // GAP=2 pacing of four samples
    do_reset();
    gap = 4'd2;
    for (int i = 0; i < 4; i++) push_one(NB'(32'h050 + i * 32'h0C3), i == 3);
    pulse_start();
    capture(10, pat);
    chk("gap2_pattern", pat, 32'h249);
    wait_eof(20);
    chk("gap2_cnt", 32'(sent_cnt), 32'd4);

    // fill: ten words offered, eight fit before START
    do_reset();
    gap = 4'd0;
    for (int i = 0; i < DEP; i++) push_one(NB'($urandom_range(0, 1023)), 1'b0);
    chk("full_ready_low", 32'(ld_ready), 32'd0);
    ld_data  = 10'h123;
    ld_valid = 1'b1;
    step();
    step();
    chk("full_still_low", 32'(ld_ready), 32'd0);
    pulse_start();
    push_one(10'h123, 1'b0);
    push_one(NB'($urandom_range(0, 1023)), 1'b1);
    wait_eof(40);
    chk("fill_cnt", 32'(sent_cnt), 32'd10);
    chk("fill_drained", 32'(exp_q.size()), 32'd0);

    // reset while in GAP with samples still queued
    do_reset();
    gap = 4'd3;
    for (int i = 0; i < 5; i++) push_one(NB'(32'h200 + i), 1'b0);
    pulse_start();
    step();
    step();
    chk("in_gap", 32'(state), 32'(ST_GAP));
    do_reset();
    chk("gaprst_vin", 32'(vin), 32'd0);
    chk("gaprst_eof", 32'(eof), 32'd0);
    chk("gaprst_cnt", 32'(sent_cnt), 32'd0);
    chk("gaprst_ready", 32'(ld_ready), 32'd1);
    chk("gaprst_state", 32'(state), 32'(ST_IDLE));
    pulse_start();
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      vcount += int'(vin);
    end
    chk("gaprst_no_vin", 32'(vcount), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
